resp_collect_ctrl: RTL and testbench
====================================

RESP_COLLECT_CTRL -- requirements
Module: resp_collect_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 1024, cycles without an accepted response before forced completion (used only with RESP_TIMEOUT_EN).
REQ-002 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port txn_valid  input  1  new transaction offered.
REQ-005 SHALL have port txn_ready  output  1  transaction accepted when txn_valid & txn_ready.
REQ-006 SHALL have port txn_mask  input  8  channels expecting a real response; 0 bits preset as fake (multicast filler).
REQ-007 SHALL have port resp_valid  input  1  one real response offered.
REQ-008 SHALL have port resp_ready  output  1  response accepted when resp_valid & resp_ready.
REQ-009 SHALL have port resp_wr_en  output  1  write strobe to external 8-entry response buffer.
REQ-010 SHALL have port resp_wr_ptr  output  3  buffer slot written this cycle.
REQ-011 SHALL have port cmpl_valid  output  1  transaction complete, buffer readable.
REQ-012 SHALL have port cmpl_ready  input  1  consumer has taken the completion.
REQ-013 SHALL have port cmpl_cnt  output  4  real responses collected (0..8).
REQ-014 SHALL have port cmpl_err  output  1  completion forced by timeout.
REQ-015 SHALL have port occ  output  8  slot occupancy vector (real or fake), debug.

Function
REQ-016 SHALL implement FSM IDLE -> COLLECT -> DRAIN -> IDLE.
REQ-017 IDLE: txn_ready=1; on txn handshake load occ=~txn_mask, push_cnt=0, cmpl_cnt=0, go COLLECT; if txn_mask==0, go directly to DRAIN.
REQ-018 COLLECT: resp_ready=1; on resp handshake resp_wr_en=1 same cycle (combinational, zero latency), resp_wr_ptr=first slot with occ=0 searching upward from push_cnt with wrap mod 8.
REQ-019 On accepted response SHALL set occ[resp_wr_ptr], set push_cnt=resp_wr_ptr+1 mod 8, increment cmpl_cnt.
REQ-020 A real response SHALL never be written to an occupied slot (real or fake).
REQ-021 When occ becomes 8'hFF, SHALL enter DRAIN next cycle; resp_ready=0 in that DRAIN cycle.
REQ-022 DRAIN: cmpl_valid=1, cmpl_cnt/cmpl_err stable until cmpl_ready; on handshake clear occ and go IDLE.
REQ-023 DRAIN with cmpl_ready=1 and txn_valid=1 SHALL also accept the new transaction (txn_ready=cmpl_ready in DRAIN) and enter COLLECT directly, loading the new mask.
REQ-024 resp_ready=0 and resp_wr_en=0 in IDLE and DRAIN; responses there stall, never drop.
REQ-025 txn_ready=0 in COLLECT.
REQ-026 cmpl_cnt SHALL equal popcount(txn_mask) on normal completion.

Reset
REQ-027 On rst_n low, asynchronously: state=IDLE, occ=0, push_cnt=0, cmpl_cnt=0, cmpl_err=0, timeout counter=0.
REQ-028 Reset outputs: txn_ready=1, resp_ready=0, resp_wr_en=0, resp_wr_ptr=0, cmpl_valid=0.
REQ-029 Reset mid-COLLECT or mid-DRAIN SHALL discard the transaction; no completion is issued.

Configuration
REQ-030 Macro RESP_TIMEOUT_EN defined: counter increments each COLLECT cycle without resp handshake, clears on handshake/entry; at TIMEOUT_CYC-1 enter DRAIN with cmpl_err=1, remaining slots left unwritten.
REQ-031 RESP_TIMEOUT_EN undefined: no counter logic, cmpl_err tied 0, COLLECT waits indefinitely.

Verification
REQ-032 txn_mask=FF, 8 responses back-to-back -> wr_ptr 0..7, cmpl_valid on cycle after 8th, cmpl_cnt=8.
REQ-033 txn_mask=0xA5, 4 responses -> wr_ptr 0,2,5,7; occ=FF; cmpl_cnt=4.
REQ-034 txn_mask=00 -> DRAIN one cycle after handshake, cmpl_cnt=0, no resp_wr_en.
REQ-035 cmpl_ready held 0 for 5 cycles in DRAIN with resp_valid=1 -> resp_ready=0, cmpl_* stable; then cmpl_ready=1 with txn_valid=1 -> next txn enters COLLECT without IDLE cycle.
REQ-036 RESP_TIMEOUT_EN, TIMEOUT_CYC=16, mask=FF, 3 responses then silence -> DRAIN 16 cycles after 3rd response, cmpl_err=1, cmpl_cnt=3.
REQ-037 rst_n low after 2 of 4 responses -> all outputs to reset values immediately, no cmpl_valid.

Source files
------------

// File: rtl/resp_collect_ctrl.sv
// Response collector: gathers up to 8 real responses into free buffer slots, then holds a completion.
// Optional macro RESP_TIMEOUT_EN forces completion (cmpl_err=1) after TIMEOUT_CYC idle COLLECT cycles.
module resp_collect_ctrl #(
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       txn_valid,
    output logic       txn_ready,
    input  logic [7:0] txn_mask,
    input  logic       resp_valid,
    output logic       resp_ready,
    output logic       resp_wr_en,
    output logic [2:0] resp_wr_ptr,
    output logic       cmpl_valid,
    input  logic       cmpl_ready,
    output logic [3:0] cmpl_cnt,
    output logic       cmpl_err,
    output logic [7:0] occ
);

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        DRAIN
    } state_t;

    state_t     state, state_nxt;
    logic [7:0] occ_q;
    logic [7:0] occ_upd;
    logic [2:0] push_cnt;
    logic [3:0] cnt_q;
    logic [2:0] free_ptr;
    logic [2:0] idx;
    logic       found;
    logic       txn_hs;
    logic       resp_hs;
    logic       cmpl_hs;
    logic       timeout_hit;

    assign txn_hs  = txn_valid & txn_ready;
    assign resp_hs = resp_valid & resp_ready;
    assign cmpl_hs = cmpl_valid & cmpl_ready;

    // First free slot at or above push_cnt, wrapping modulo 8.
    always_comb begin
        free_ptr = '0;
        found    = 1'b0;
        idx      = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            idx = push_cnt + 3'(i);
            if (!found && !occ_q[idx]) begin
                free_ptr = idx;
                found    = 1'b1;
            end
        end
    end

    assign occ_upd = occ_q | (8'b1 << free_ptr);

`ifdef RESP_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYC) + 1;

    logic [TO_W-1:0] to_cnt;
    logic            err_q;

    // Counter only runs while COLLECT sees no handshake; any other cycle clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt <= '0;
        end else if (state == COLLECT && !resp_hs) begin
            to_cnt <= to_cnt + 1'b1;
        end else begin
            to_cnt <= '0;
        end
    end

    assign timeout_hit = (state == COLLECT) && !resp_hs && (to_cnt == TO_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (txn_hs) begin
            err_q <= 1'b0;
        end else if (timeout_hit) begin
            err_q <= 1'b1;
        end
    end

    assign cmpl_err = err_q;
`else
    assign timeout_hit = 1'b0;
    assign cmpl_err    = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (txn_valid) begin
                    state_nxt = (txn_mask == 8'h00) ? DRAIN : COLLECT;
                end
            end
            COLLECT: begin
                if (resp_hs && occ_upd == 8'hFF) begin
                    state_nxt = DRAIN;
                end else if (timeout_hit) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (cmpl_ready) begin
                    if (txn_valid) begin
                        state_nxt = (txn_mask == 8'h00) ? DRAIN : COLLECT;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        txn_ready   = 1'b0;
        resp_ready  = 1'b0;
        resp_wr_en  = 1'b0;
        resp_wr_ptr = '0;
        cmpl_valid  = 1'b0;
        case (state)
            IDLE: begin
                txn_ready = 1'b1;
            end
            COLLECT: begin
                resp_ready  = 1'b1;
                resp_wr_en  = resp_valid;
                resp_wr_ptr = free_ptr;
            end
            DRAIN: begin
                cmpl_valid = 1'b1;
                txn_ready  = cmpl_ready;
            end
            default: ;
        endcase
    end

    // A new transaction accepted in DRAIN overrides the occupancy clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_q    <= '0;
            push_cnt <= '0;
            cnt_q    <= '0;
        end else if (txn_hs) begin
            occ_q    <= ~txn_mask;
            push_cnt <= '0;
            cnt_q    <= '0;
        end else if (cmpl_hs) begin
            occ_q <= '0;
        end else if (resp_hs) begin
            occ_q    <= occ_upd;
            push_cnt <= free_ptr + 3'd1;
            cnt_q    <= cnt_q + 4'd1;
        end
    end

    assign occ      = occ_q;
    assign cmpl_cnt = cnt_q;

endmodule

// File: tb/tb_resp_collect_ctrl.sv
// Directed self-checking bench for resp_collect_ctrl; inputs change on the falling edge.
module tb_resp_collect_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       txn_valid;
    logic       txn_ready;
    logic [7:0] txn_mask;
    logic       resp_valid;
    logic       resp_ready;
    logic       resp_wr_en;
    logic [2:0] resp_wr_ptr;
    logic       cmpl_valid;
    logic       cmpl_ready;
    logic [3:0] cmpl_cnt;
    logic       cmpl_err;
    logic [7:0] occ;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    always #5 clk = ~clk;

    resp_collect_ctrl #(.TIMEOUT_CYC(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .txn_valid(txn_valid), .txn_ready(txn_ready), .txn_mask(txn_mask),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_wr_en(resp_wr_en), .resp_wr_ptr(resp_wr_ptr),
        .cmpl_valid(cmpl_valid), .cmpl_ready(cmpl_ready),
        .cmpl_cnt(cmpl_cnt), .cmpl_err(cmpl_err), .occ(occ)
    );

    task automatic step(input logic tv, input logic [7:0] tm, input logic rv, input logic cr);
        @(negedge clk);
        txn_valid  = tv;
        txn_mask   = tm;
        resp_valid = rv;
        cmpl_ready = cr;
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        txn_valid = 1'b0; txn_mask = 8'h00; resp_valid = 1'b1; cmpl_ready = 1'b0;
        #12;
        n_vec++;
        if ({txn_ready, resp_ready, resp_wr_en, resp_wr_ptr, cmpl_valid, cmpl_cnt, cmpl_err, occ}
            !== {1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 4'd0, 1'b0, 8'h00}) begin
            n_err++;
            $display("FAIL reset_outputs: got rdy=%b rr=%b we=%b ptr=%0d cv=%b cnt=%0d err=%b occ=%h",
                     txn_ready, resp_ready, resp_wr_en, resp_wr_ptr, cmpl_valid, cmpl_cnt, cmpl_err, occ);
        end
        @(negedge clk);
        rst_n = 1'b1;
        resp_valid = 1'b0;
    endtask

    task automatic test_full_mask;
        step(1'b1, 8'hFF, 1'b0, 1'b0);
        n_vec++;
        if (txn_ready !== 1'b1) begin n_err++; $display("FAIL full_txn_ready: got %b want 1", txn_ready); end
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 8'h00, 1'b1, 1'b0);
            n_vec++;
            if ({resp_ready, resp_wr_en, resp_wr_ptr, txn_ready} !== {1'b1, 1'b1, 3'(i), 1'b0}) begin
                n_err++;
                $display("FAIL full_wr_ptr[%0d]: got rr=%b we=%b ptr=%0d tr=%b want 1 1 %0d 0",
                         i, resp_ready, resp_wr_en, resp_wr_ptr, txn_ready, i);
            end
        end
        step(1'b0, 8'h00, 1'b1, 1'b0);
        n_vec++;
        if ({cmpl_valid, cmpl_cnt, cmpl_err, occ, resp_ready, resp_wr_en}
            !== {1'b1, 4'd8, 1'b0, 8'hFF, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL full_drain: got cv=%b cnt=%0d err=%b occ=%h rr=%b we=%b want 1 8 0 ff 0 0",
                     cmpl_valid, cmpl_cnt, cmpl_err, occ, resp_ready, resp_wr_en);
        end
        step(1'b0, 8'h00, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        n_vec++;
        if ({cmpl_valid, occ, txn_ready} !== {1'b0, 8'h00, 1'b1}) begin
            n_err++;
            $display("FAIL full_to_idle: got cv=%b occ=%h tr=%b want 0 00 1", cmpl_valid, occ, txn_ready);
        end
    endtask

    task automatic test_sparse_mask;
        logic [2:0] exp_ptr [4];
        exp_ptr = '{3'd0, 3'd2, 3'd5, 3'd7};
        step(1'b1, 8'hA5, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        n_vec++;
        if (occ !== 8'h5A) begin n_err++; $display("FAIL sparse_occ_load: got %h want 5a", occ); end
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 8'h00, 1'b1, 1'b0);
            n_vec++;
            if ({resp_wr_en, resp_wr_ptr} !== {1'b1, exp_ptr[i]}) begin
                n_err++;
                $display("FAIL sparse_wr_ptr[%0d]: got we=%b ptr=%0d want 1 %0d", i, resp_wr_en, resp_wr_ptr, exp_ptr[i]);
            end
        end
        step(1'b0, 8'h00, 1'b0, 1'b0);
        n_vec++;
        if ({cmpl_valid, cmpl_cnt, occ} !== {1'b1, 4'd4, 8'hFF}) begin
            n_err++;
            $display("FAIL sparse_drain: got cv=%b cnt=%0d occ=%h want 1 4 ff", cmpl_valid, cmpl_cnt, occ);
        end
        step(1'b0, 8'h00, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic test_zero_mask;
        step(1'b1, 8'h00, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        n_vec++;
        if ({cmpl_valid, cmpl_cnt, resp_wr_en, resp_ready} !== {1'b1, 4'd0, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL zero_mask_drain: got cv=%b cnt=%0d we=%b rr=%b want 1 0 0 0",
                     cmpl_valid, cmpl_cnt, resp_wr_en, resp_ready);
        end
        step(1'b0, 8'h00, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        n_vec++;
        if (cmpl_valid !== 1'b0) begin n_err++; $display("FAIL zero_mask_idle: got cv=%b want 0", cmpl_valid); end
    endtask

    task automatic test_back_to_back;
        step(1'b1, 8'h03, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 8'h00, 1'b1, 1'b0);
            n_vec++;
            if ({cmpl_valid, cmpl_cnt, cmpl_err, resp_ready, resp_wr_en, txn_ready}
                !== {1'b1, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0}) begin
                n_err++;
                $display("FAIL b2b_stall[%0d]: got cv=%b cnt=%0d err=%b rr=%b we=%b tr=%b want 1 2 0 0 0 0",
                         i, cmpl_valid, cmpl_cnt, cmpl_err, resp_ready, resp_wr_en, txn_ready);
            end
        end
        step(1'b1, 8'h30, 1'b1, 1'b1);
        n_vec++;
        if ({txn_ready, resp_wr_en} !== {1'b1, 1'b0}) begin
            n_err++;
            $display("FAIL b2b_accept: got tr=%b we=%b want 1 0", txn_ready, resp_wr_en);
        end
        step(1'b0, 8'h00, 1'b1, 1'b0);
        n_vec++;
        if ({cmpl_valid, resp_ready, occ, resp_wr_ptr, cmpl_cnt} !== {1'b0, 1'b1, 8'hCF, 3'd4, 4'd0}) begin
            n_err++;
            $display("FAIL b2b_collect: got cv=%b rr=%b occ=%h ptr=%0d cnt=%0d want 0 1 cf 4 0",
                     cmpl_valid, resp_ready, occ, resp_wr_ptr, cmpl_cnt);
        end
        step(1'b0, 8'h00, 1'b1, 1'b0);
        n_vec++;
        if (resp_wr_ptr !== 3'd5) begin n_err++; $display("FAIL b2b_ptr2: got %0d want 5", resp_wr_ptr); end
        step(1'b0, 8'h00, 1'b0, 1'b0);
        n_vec++;
        if ({cmpl_valid, cmpl_cnt} !== {1'b1, 4'd2}) begin
            n_err++;
            $display("FAIL b2b_drain2: got cv=%b cnt=%0d want 1 2", cmpl_valid, cmpl_cnt);
        end
        step(1'b0, 8'h00, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid;
        step(1'b1, 8'h0F, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0);
        n_vec++;
        if (resp_wr_ptr !== 3'd1) begin n_err++; $display("FAIL rstmid_ptr: got %0d want 1", resp_wr_ptr); end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({txn_ready, resp_ready, resp_wr_en, resp_wr_ptr, cmpl_valid, cmpl_cnt, occ}
            !== {1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 4'd0, 8'h00}) begin
            n_err++;
            $display("FAIL rstmid_async: got tr=%b rr=%b we=%b ptr=%0d cv=%b cnt=%0d occ=%h",
                     txn_ready, resp_ready, resp_wr_en, resp_wr_ptr, cmpl_valid, cmpl_cnt, occ);
        end
        step(1'b0, 8'h00, 1'b0, 1'b0);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 8'h00, 1'b1, 1'b1);
            n_vec++;
            if ({cmpl_valid, resp_ready, txn_ready} !== {1'b0, 1'b0, 1'b1}) begin
                n_err++;
                $display("FAIL rstmid_after[%0d]: got cv=%b rr=%b tr=%b want 0 0 1", i, cmpl_valid, resp_ready, txn_ready);
            end
        end
        step(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

`ifdef RESP_TIMEOUT_EN
    task automatic test_timeout;
        step(1'b1, 8'hFF, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 8'h00, 1'b0, 1'b0);
            n_vec++;
            if ({cmpl_valid, resp_ready} !== {1'b0, 1'b1}) begin
                n_err++;
                $display("FAIL timeout_wait[%0d]: got cv=%b rr=%b want 0 1", i, cmpl_valid, resp_ready);
            end
        end
        step(1'b0, 8'h00, 1'b0, 1'b0);
        n_vec++;
        if ({cmpl_valid, cmpl_err, cmpl_cnt, occ} !== {1'b1, 1'b1, 4'd3, 8'h07}) begin
            n_err++;
            $display("FAIL timeout_drain: got cv=%b err=%b cnt=%0d occ=%h want 1 1 3 07",
                     cmpl_valid, cmpl_err, cmpl_cnt, occ);
        end
        step(1'b0, 8'h00, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b0);
    endtask
`endif

    initial begin
        test_reset;
        test_full_mask;
        test_sparse_mask;
        test_zero_mask;
        test_back_to_back;
        test_reset_mid;
`ifdef RESP_TIMEOUT_EN
        test_timeout;
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
